// File: rtl/noise_gen_pkg.sv
// Shared constants for the noise/sine source block: LFSR defaults and the
// quarter-wave sine table with its full-circle lookup function.
package noise_gen_pkg;

    localparam int          LFSR_WIDTH   = 32;
    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;
    localparam logic [31:0] LFSR_MASK    = 32'h8020_0003;

    localparam int          SIN_DEPTH = 256;
    localparam int          SIN_WIDTH = 8;
    localparam logic [7:0]  SIN_MID   = 8'd128;

    // round(128 + 127*sin(2*pi*k/256)) for k = 0..64
    localparam logic [7:0] SIN_QUARTER [0:64] = '{
        8'd128, 8'd131, 8'd134, 8'd137, 8'd140, 8'd144, 8'd147, 8'd150,
        8'd153, 8'd156, 8'd159, 8'd162, 8'd165, 8'd168, 8'd171, 8'd174,
        8'd177, 8'd179, 8'd182, 8'd185, 8'd188, 8'd191, 8'd193, 8'd196,
        8'd199, 8'd201, 8'd204, 8'd206, 8'd209, 8'd211, 8'd213, 8'd216,
        8'd218, 8'd220, 8'd222, 8'd224, 8'd226, 8'd228, 8'd230, 8'd232,
        8'd234, 8'd235, 8'd237, 8'd239, 8'd240, 8'd241, 8'd243, 8'd244,
        8'd245, 8'd246, 8'd248, 8'd249, 8'd250, 8'd250, 8'd251, 8'd252,
        8'd253, 8'd253, 8'd254, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255,
        8'd255
    };

    // Second/fourth quadrants mirror the index; lower half negates about 128.
    function automatic logic [7:0] sin_value(input logic [7:0] k);
        logic [6:0] idx;
        logic [7:0] mag;
        idx = k[6] ? (7'd64 - {1'b0, k[5:0]}) : {1'b0, k[5:0]};
        mag = SIN_QUARTER[idx];
        return k[7] ? 8'(9'd256 - {1'b0, mag}) : mag;
    endfunction

endpackage

// File: rtl/noise_generator_sin_rom.sv
// Sine lookup with a single output register; the address is not staged,
// so q reflects the address sampled at the previous rising edge.
module sin_rom
    import noise_gen_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] address,
    output logic [7:0] q
);

    logic [7:0] q_d;
    logic [7:0] q_q;

    always_comb begin
        q_d = sin_value(address);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= SIN_MID;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/noise_generator.sv
// Continuous noise and sine sources for the waveform selector: a 32-bit
// Galois LFSR whose state is the noise output, plus a registered sine lookup.
module noise_generator
    import noise_gen_pkg::*;
#(
    parameter logic [31:0] SEED      = noise_gen_pkg::DEFAULT_SEED,
    parameter logic [31:0] LFSR_MASK = noise_gen_pkg::LFSR_MASK
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  sin_address,
    output logic [7:0]  sin_q,
    output logic [31:0] noise
);

    // An all-zero seed would lock the LFSR, so it is replaced by the default.
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? DEFAULT_SEED : SEED;

    logic [31:0] lfsr_d;
    logic [31:0] lfsr_q;

    always_comb begin
        if (lfsr_q == 32'h0) begin
            lfsr_d = SEED_EFF;
        end else begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign noise = lfsr_q;

    sin_rom u_sin_rom (
        .clk     (clk),
        .rst_n   (rst_n),
        .address (sin_address),
        .q       (sin_q)
    );

endmodule

// File: tb/tb_noise_generator.sv
// Directed bench for noise_generator: reset values, LFSR sequence and
// guard, sine table sweep and latency, asynchronous reset.
module tb_noise_generator;

    logic        clk;
    logic        rst_n;
    logic [7:0]  sin_address;
    logic [7:0]  sin_q;
    logic [31:0] noise;

    int n_checks;
    int n_fails;

    noise_generator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sin_address (sin_address),
        .sin_q       (sin_q),
        .noise       (noise)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ref_sin(input int k);
        real v;
        v = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 256.0);
        return int'($floor(v + 0.5));
    endfunction

    function automatic logic [31:0] ref_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    logic [7:0]  obs [0:255];
    logic [31:0] exp_seq [0:2];
    logic [7:0]  b2b_addr [0:2];
    logic [7:0]  b2b_exp [0:2];

    initial begin
        int sweep_err;
        int sym_err;
        int eq_err;
        int zero_cnt;
        int ones_cnt;
        int in_window;
        logic [31:0] prev;

        n_checks = 0;
        n_fails  = 0;
        exp_seq[0] = 32'h8020_0003;
        exp_seq[1] = 32'hC030_0002;
        exp_seq[2] = 32'h6018_0001;
        b2b_addr[0] = 8'd64;  b2b_exp[0] = 8'd255;
        b2b_addr[1] = 8'd192; b2b_exp[1] = 8'd1;
        b2b_addr[2] = 8'd64;  b2b_exp[2] = 8'd255;

        rst_n = 1'b0;
        sin_address = 8'd64;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_noise", noise, 32'h0000_0001);
        check_eq("reset_sin", {24'h0, sin_q}, 32'd128);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("lfsr_step%0d", i + 1), noise, exp_seq[i]);
        end

        // Sine sweep, one address per cycle, observed one edge later.
        sweep_err = 0;
        for (int k = 0; k < 256; k++) begin
            sin_address = 8'(k);
            @(posedge clk);
            #1;
            obs[k] = sin_q;
            if (int'(sin_q) != ref_sin(k)) begin
                sweep_err++;
                if (sweep_err <= 4)
                    $display("FAIL sin_sweep k=%0d: got %0d, expected %0d", k, sin_q, ref_sin(k));
            end
        end
        check_eq("sin_sweep_errors", sweep_err, 0);
        check_eq("sin_k0", {24'h0, obs[0]}, 32'd128);
        check_eq("sin_k32", {24'h0, obs[32]}, 32'd218);
        check_eq("sin_k64", {24'h0, obs[64]}, 32'd255);
        check_eq("sin_k128", {24'h0, obs[128]}, 32'd128);
        check_eq("sin_k192", {24'h0, obs[192]}, 32'd1);
        check_eq("sin_k224", {24'h0, obs[224]}, 32'd38);

        sym_err = 0;
        for (int k = 1; k < 128; k++) begin
            if (int'(obs[k]) + int'(obs[256 - k]) != 256)
                sym_err++;
        end
        check_eq("sin_symmetry_errors", sym_err, 0);

        for (int i = 0; i < 3; i++) begin
            sin_address = b2b_addr[i];
            @(posedge clk);
            #1;
            check_eq($sformatf("sin_b2b%0d", i), {24'h0, sin_q}, {24'h0, b2b_exp[i]});
        end

        // Long LFSR run: next-state equation, non-zero, bit-31 balance.
        eq_err = 0;
        zero_cnt = 0;
        ones_cnt = 0;
        prev = noise;
        for (int c = 0; c < 60000; c++) begin
            @(posedge clk);
            #1;
            if (noise !== ref_next(prev)) eq_err++;
            if (noise == 32'h0) zero_cnt++;
            if (noise[31]) ones_cnt++;
            prev = noise;
        end
        check_eq("lfsr_equation_errors", eq_err, 0);
        check_eq("lfsr_zero_count", zero_cnt, 0);
        in_window = (ones_cnt >= 29400 && ones_cnt <= 30600) ? 1 : 0;
        if (in_window == 0)
            $display("bit31 high count %0d of 60000", ones_cnt);
        check_eq("lfsr_bit31_balance", in_window, 1);

        // Zero-lockup guard.
        @(negedge clk);
        force dut.lfsr_q = 32'h0;
        #1;
        release dut.lfsr_q;
        check_eq("lockup_forced_zero", noise, 32'h0);
        @(posedge clk);
        #1;
        check_eq("lockup_recover", noise, 32'h0000_0001);
        @(posedge clk);
        #1;
        check_eq("lockup_after", noise, 32'h8020_0003);

        // Asynchronous reset between edges.
        sin_address = 8'd64;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        sin_address = 8'd192;
        #1;
        check_eq("async_rst_noise", noise, 32'h0000_0001);
        check_eq("async_rst_sin", {24'h0, sin_q}, 32'd128);
        @(posedge clk);
        #1;
        check_eq("rst_hold_sin", {24'h0, sin_q}, 32'd128);
        check_eq("rst_hold_noise", noise, 32'h0000_0001);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst_sin", {24'h0, sin_q}, 32'd1);
        check_eq("post_rst_noise", noise, 32'h8020_0003);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
